// File: rtl/apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// apb_master_arbiter
//   APB4 requester-side controller. Shares one APB bus among NUM_REQ internal
//   requesters using round-robin arbitration. It captures the winning request,
//   sequences the SETUP/ACCESS phases and absorbs slave wait states. A stalled
//   ACCESS phase ends after TIMEOUT_CYCLES wait cycles (0 = never). Each
//   transfer returns a one-cycle response to the requester that issued it.
//
// Ports
//   pclk, presetn          : clock (rising edge), async active-low reset
//   req_valid[NUM_REQ]     : request pending per requester
//   req_ready[NUM_REQ]     : one-hot accept strobe (combinational)
//   req_addr/wdata (32b ea), req_write, req_strb (4b ea), req_prot (3b ea)
//                          : packed per-requester request fields
//   rsp_valid[NUM_REQ]     : one-hot, one-cycle completion strobe
//   rsp_rdata, rsp_slverr  : completion data / error
//   paddr, pprot, psel, penable, pwrite, pwdata, pstrb : APB master outputs
//   pready, prdata, pslverr                            : APB slave returns
// -----------------------------------------------------------------------------
module apb_master_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ-1:0]   req_write,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  input  logic [NUM_REQ*4-1:0] req_strb,
  input  logic [NUM_REQ*3-1:0] req_prot,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_slverr,
  output logic [31:0]          paddr,
  output logic [2:0]           pprot,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [31:0]          pwdata,
  output logic [3:0]           pstrb,
  input  logic                 pready,
  input  logic [31:0]          prdata,
  input  logic                 pslverr
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Counter value seen during the last permitted wait cycle.
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   cur_idx;
  logic            gnt_found;
  logic            arb_en;
  logic            accept;
  logic            done;
  logic            to_hit;
  logic [CW-1:0]   to_cnt;

  logic [31:0]     sel_addr;
  logic [31:0]     sel_wdata;
  logic [3:0]      sel_strb;
  logic [2:0]      sel_prot;
  logic            sel_write;

  // ---- arbitration / request select (combinational) ----
  // Scanning offsets from high to low lets the lowest offset from ptr win.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr) + k) % NUM_REQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'((int'(ptr) + k) % NUM_REQ);
      end
    end
    ptr_nxt = PW'((int'(gnt_idx) + 1) % NUM_REQ);
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_strb  = '0;
    sel_prot  = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == PW'(i)) begin
        sel_addr  = req_addr[32*i +: 32];
        sel_wdata = req_wdata[32*i +: 32];
        sel_strb  = req_strb[4*i +: 4];
        sel_prot  = req_prot[3*i +: 3];
        sel_write = req_write[i];
      end
    end
  end

  assign done   = (state == ACCESS) && pready;
  // Timeout only applies while the slave is still stalling; a timed-out
  // cycle therefore never coincides with a completion or a new grant.
  assign to_hit = (TIMEOUT_CYCLES != 0) && (state == ACCESS) && !pready &&
                  (to_cnt == TO_LAST);
  assign arb_en = (state == IDLE) || done;
  assign accept = arb_en && gnt_found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_found) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS: begin
        if (done)        state_nxt = gnt_found ? SETUP : IDLE;
        else if (to_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- registered APB outputs, response and control ----
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state      <= IDLE;
      ptr        <= '0;
      cur_idx    <= '0;
      to_cnt     <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      pstrb      <= '0;
      pprot      <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
    end else begin
      state   <= state_nxt;
      psel    <= (state_nxt != IDLE);
      penable <= (state_nxt == ACCESS);

      if (accept) begin
        ptr     <= ptr_nxt;
        cur_idx <= gnt_idx;
        paddr   <= sel_addr;
        pprot   <= sel_prot;
        pwrite  <= sel_write;
        // Reads keep the previous pwdata and drive no byte strobes.
        if (sel_write) begin
          pwdata <= sel_wdata;
          pstrb  <= sel_strb;
        end else begin
          pstrb  <= '0;
        end
      end

      if (state == SETUP)
        to_cnt <= '0;
      else if ((state == ACCESS) && !pready)
        to_cnt <= to_cnt + CW'(1);

      // Response refers to cur_idx, which still holds the finishing transfer
      // even when a new grant is latched on this same edge.
      rsp_valid <= '0;
      if (done) begin
        rsp_valid[cur_idx] <= 1'b1;
        rsp_rdata          <= pwrite ? 32'h0 : prdata;
        rsp_slverr         <= pslverr;
      end else if (to_hit) begin
        rsp_valid[cur_idx] <= 1'b1;
        rsp_rdata          <= 32'h0;
        rsp_slverr         <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_master_arbiter
//   Directed bench for apb_master_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=4).
//   Inputs change 1 ns after the rising edge; registered outputs are sampled
//   there too, and req_ready is sampled 1 ns after the inputs settle.
// -----------------------------------------------------------------------------
module tb_apb_master_arbiter;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [1:0]  req_valid, req_ready, req_write, rsp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_strb;
  logic [5:0]  req_prot;
  logic [31:0] rsp_rdata, paddr, pwdata, prdata;
  logic        rsp_slverr, psel, penable, pwrite, pready, pslverr;
  logic [2:0]  pprot;
  logic [3:0]  pstrb;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  apb_master_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(4)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
    .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    presetn   = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    req_strb  = '0; req_prot  = '0;
    pready    = 1'b0; prdata = '0; pslverr = 1'b0;

    // ---- reset state ----
    tick(); tick();
    chk("rst_psel", psel, 0);        chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);    chk("rst_pstrb", pstrb, 0);
    chk("rst_pprot", pprot, 0);      chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_slverr", rsp_slverr, 0); chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_req_ready", req_ready, 0);
    presetn = 1'b1;
    tick();

    // ---- single write from req0, zero wait ----
    req_valid = 2'b01; req_write = 2'b01;
    req_addr[31:0] = 32'h0000_0010; req_wdata[31:0] = 32'hDEAD_BEEF;
    req_strb[3:0] = 4'hF; req_prot[2:0] = 3'b101; pready = 1'b1;
    #1 chk("wr_ready", req_ready, 2'b01);
    tick();
    chk("wr_setup_psel", psel, 1); chk("wr_setup_pen", penable, 0);
    chk("wr_setup_paddr", paddr, 32'h10);
    req_valid = 2'b00;
    #1 chk("wr_setup_ready", req_ready, 0);
    tick();
    chk("wr_acc_psel", psel, 1);     chk("wr_acc_pen", penable, 1);
    chk("wr_acc_paddr", paddr, 32'h10); chk("wr_acc_pwrite", pwrite, 1);
    chk("wr_acc_pstrb", pstrb, 4'hF);   chk("wr_acc_pwdata", pwdata, 32'hDEAD_BEEF);
    chk("wr_acc_pprot", pprot, 3'b101); chk("wr_acc_rsp", rsp_valid, 0);
    tick();
    chk("wr_rsp_valid", rsp_valid, 2'b01); chk("wr_rsp_slverr", rsp_slverr, 0);
    chk("wr_rsp_rdata", rsp_rdata, 0);     chk("wr_idle_psel", psel, 0);

    // ---- simultaneous reads after reset: grants 0,1,0,1 back-to-back ----
    presetn = 1'b0;
    tick();
    presetn = 1'b1;
    req_valid = 2'b11; req_write = 2'b00;
    req_addr = {32'h0000_0200, 32'h0000_0100}; req_strb = 8'hFF;
    pready = 1'b1; prdata = 32'hA0;
    #1 chk("rr_g0_ready", req_ready, 2'b01);
    tick();
    chk("rr_s0_paddr", paddr, 32'h100); chk("rr_s0_pstrb", pstrb, 0);
    chk("rr_s0_pen", penable, 0);
    tick();
    chk("rr_a0_pen", penable, 1);
    chk("rr_a0_ready", req_ready, 2'b10);
    tick();
    chk("rr_s1_psel", psel, 1);       chk("rr_s1_pen", penable, 0);
    chk("rr_s1_paddr", paddr, 32'h200);
    chk("rr_rsp0_valid", rsp_valid, 2'b01); chk("rr_rsp0_rdata", rsp_rdata, 32'hA0);
    prdata = 32'hB1;
    tick();
    chk("rr_a1_ready", req_ready, 2'b01);
    tick();
    chk("rr_s2_psel", psel, 1);       chk("rr_s2_paddr", paddr, 32'h100);
    chk("rr_rsp1_valid", rsp_valid, 2'b10); chk("rr_rsp1_rdata", rsp_rdata, 32'hB1);
    prdata = 32'hC2;
    tick();
    chk("rr_a2_ready", req_ready, 2'b10);
    tick();
    chk("rr_s3_psel", psel, 1);       chk("rr_s3_paddr", paddr, 32'h200);
    chk("rr_rsp2_valid", rsp_valid, 2'b01); chk("rr_rsp2_rdata", rsp_rdata, 32'hC2);
    req_valid = 2'b00; prdata = 32'hD3;
    tick();
    chk("rr_a3_ready", req_ready, 0);
    tick();
    chk("rr_rsp3_valid", rsp_valid, 2'b10); chk("rr_rsp3_rdata", rsp_rdata, 32'hD3);
    chk("rr_end_psel", psel, 0);

    // ---- read from req1 with three wait states ----
    req_valid = 2'b10; req_addr[63:32] = 32'h0000_0300; pready = 1'b0;
    #1 chk("ws_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    chk("ws_setup_pstrb", pstrb, 0); chk("ws_setup_paddr", paddr, 32'h300);
    tick(); chk("ws_a1_pen", penable, 1);
    tick(); chk("ws_a2_pen", penable, 1); chk("ws_a2_paddr", paddr, 32'h300);
    tick(); chk("ws_a3_pen", penable, 1); chk("ws_a3_paddr", paddr, 32'h300);
    tick(); chk("ws_a4_pen", penable, 1); chk("ws_a4_paddr", paddr, 32'h300);
    chk("ws_a4_rsp", rsp_valid, 0);
    pready = 1'b1; prdata = 32'h5A5A;
    tick();
    chk("ws_rsp_valid", rsp_valid, 2'b10); chk("ws_rsp_rdata", rsp_rdata, 32'h5A5A);
    chk("ws_rsp_slverr", rsp_slverr, 0);   chk("ws_idle_psel", psel, 0);
    pready = 1'b0;

    // ---- timeout after 4 stalled ACCESS cycles ----
    req_valid = 2'b01; req_addr[31:0] = 32'h0000_0400;
    #1 chk("to_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    tick(); chk("to_a1_pen", penable, 1);
    tick(); tick();
    tick(); chk("to_a4_psel", psel, 1); chk("to_a4_pen", penable, 1);
    req_valid = 2'b10;
    #1 chk("to_a4_no_grant", req_ready, 0);
    req_valid = 2'b00;
    tick();
    chk("to_psel", psel, 0);             chk("to_pen", penable, 0);
    chk("to_rsp_valid", rsp_valid, 2'b01); chk("to_rsp_slverr", rsp_slverr, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    pready = 1'b1; prdata = 32'hFFFF_FFFF;
    tick();
    chk("to_late_rsp", rsp_valid, 0); chk("to_late_psel", psel, 0);

    // ---- slave error on a write, then clean read back-to-back ----
    req_valid = 2'b10; req_write = 2'b10;
    req_addr[63:32] = 32'h0000_0500; req_wdata[63:32] = 32'h0000_1234;
    req_strb[7:4] = 4'h3; pready = 1'b1; pslverr = 1'b1;
    #1 chk("se_ready", req_ready, 2'b10);
    tick();
    chk("se_pwdata", pwdata, 32'h1234); chk("se_pstrb", pstrb, 4'h3);
    chk("se_pwrite", pwrite, 1);
    req_valid = 2'b00;
    tick();
    req_valid = 2'b01; req_write = 2'b00; req_addr[31:0] = 32'h0000_0600;
    #1 chk("se_b2b_ready", req_ready, 2'b01);
    tick();
    chk("se_rsp_valid", rsp_valid, 2'b10); chk("se_rsp_slverr", rsp_slverr, 1);
    chk("se_b2b_psel", psel, 1);           chk("se_b2b_pen", penable, 0);
    chk("se_b2b_paddr", paddr, 32'h600);   chk("se_b2b_pstrb", pstrb, 0);
    chk("se_b2b_pwdata_held", pwdata, 32'h1234);
    req_valid = 2'b00; pslverr = 1'b0; prdata = 32'h77;
    tick();
    tick();
    chk("se2_rsp_valid", rsp_valid, 2'b01); chk("se2_rsp_slverr", rsp_slverr, 0);
    chk("se2_rsp_rdata", rsp_rdata, 32'h77);

    // ---- async reset mid-ACCESS, pointer returns to 0 ----
    req_valid = 2'b01; req_addr[31:0] = 32'h0000_0700; pready = 1'b0;
    #1 chk("ar_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    tick();
    chk("ar_acc_pen", penable, 1);
    #3 presetn = 1'b0;
    #1;
    chk("ar_psel", psel, 0); chk("ar_pen", penable, 0); chk("ar_paddr", paddr, 0);
    tick();
    chk("ar_rsp_in_reset", rsp_valid, 0);
    presetn = 1'b1;
    tick();
    chk("ar_rsp_after", rsp_valid, 0); chk("ar_psel_after", psel, 0);
    req_valid = 2'b11;
    #1 chk("ar_ptr_zero", req_ready, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

APB4 requester-side controller that shares one APB bus among `NUM_REQ` internal requesters. It arbitrates round-robin, captures the winning request, and sequences the APB SETUP/ACCESS phases toward the slave. It also absorbs wait states, enforces a wait-state timeout and returns a one-cycle response to the originating requester.

## Interface
- `NUM_REQ`, 2: number of requesters (2..8).
- `TIMEOUT_CYCLES`, 16: max ACCESS cycles with `pready`=0 before forced termination; 0 disables the timeout.
- `pclk` in 1: single clock; all logic on rising edge.
- `presetn` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester request pending.
- `req_ready` out NUM_REQ: one-hot grant/accept strobe (combinational).
- `req_addr` in NUM_REQ*32: packed addresses; requester i at [32i+31:32i].
- `req_write` in NUM_REQ: 1 = write.
- `req_wdata` in NUM_REQ*32: packed write data.
- `req_strb` in NUM_REQ*4: packed byte strobes.
- `req_prot` in NUM_REQ*3: packed protection attributes.
- `rsp_valid` out NUM_REQ: one-hot, one-cycle completion strobe.
- `rsp_rdata` out 32: read data for the completing transfer.
- `rsp_slverr` out 1: error for the completing transfer.
- `paddr` out 32, `pprot` out 3, `psel` out 1, `penable` out 1, `pwrite` out 1, `pwdata` out 32, `pstrb` out 4: APB master outputs.
- `pready` in 1, `prdata` in 32, `pslverr` in 1: APB slave returns.

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE: `psel`=0, `penable`=0. If any `req_valid`, the arbiter selects a winner i and asserts `req_ready[i]` in the same cycle. At that edge, addr/write/wdata/strb/prot of i are latched into the APB output registers, the grant index is stored, and the state moves to SETUP.
- SETUP: `psel`=1, `penable`=0. Always advances to ACCESS after one cycle.
- ACCESS: `psel`=1, `penable`=1. All APB outputs stay stable.
  - On an edge with `pready`=1: the transfer completes and `rsp_rdata`/`rsp_slverr` are registered from `prdata`/`pslverr`.
  - If `req_valid` is nonzero in that cycle, arbitration runs again and the winner's `req_ready` asserts. The next state is SETUP, `psel` stays 1 and `penable` drops to 0 (back-to-back).
  - Otherwise the next state is IDLE.
- Round-robin arbitration:
  - A pointer gives priority to index `ptr`, then `ptr+1`, … wrapping modulo NUM_REQ.
  - On each grant, the pointer becomes grant+1 (mod NUM_REQ).
  - Reset value of the pointer is 0.
- `req_ready` is asserted only in IDLE or in ACCESS with `pready`=1; it is 0 in every other cycle. A requester holds `req_valid` and its fields stable until accepted.
- Reads: `pstrb` is driven as 4'b0000 and `pwdata` is don't-care (held at its last value).
- `rsp_rdata` is 0 for writes.
- Timeout:
  - The counter clears on entry to ACCESS and increments each ACCESS cycle with `pready`=0.
  - When it reaches TIMEOUT_CYCLES (if nonzero), the transfer terminates: `rsp_valid[i]`=1, `rsp_slverr`=1, `rsp_rdata`=0, and the next state is IDLE with `psel`=0. No new grant is issued in that cycle.
  - A later `pready` from the slave is ignored.
- Response: `rsp_valid[i]` is high for exactly the cycle after completion; otherwise 0.

## Timing
- Reset (`presetn`=0, async): state IDLE, pointer 0, timeout counter 0.
  - Outputs: `psel`, `penable`, `pwrite` = 0; `paddr`, `pwdata`, `rsp_rdata` = 0; `pstrb`, `pprot` = 0; `rsp_valid` = 0; `rsp_slverr` = 0.
  - `req_ready` is therefore 0.
- Reset mid-transfer: the bus is abandoned immediately, and no `rsp_valid` is issued for the aborted transfer.
- Zero-wait transfer, accept in cycle T:
  - T+1: SETUP.
  - T+2: ACCESS with `pready`=1.
  - T+3: `rsp_valid`.
- Each wait cycle adds one cycle.
- Back-to-back transfers: one SETUP cycle between ACCESS phases; `psel` never drops.
- Completion and a new grant in the same cycle: the new request's latch and the old response's registration occur on the same edge; both are required.
- All APB outputs and `rsp_*` are registered. Only `req_ready` is combinational, from `req_valid`, state, `pready`, the pointer and the timeout condition.

## Test plan
- Single write: req0 addr 0x0000_0010, wdata 0xDEAD_BEEF, strb 0xF, `pready`=1 -> SETUP at T+1, ACCESS at T+2 with `paddr`=0x10, `pwrite`=1, `pstrb`=0xF; `rsp_valid`=01 at T+3, `rsp_slverr`=0.
- Simultaneous requests: req0 and req1 both held valid (reads) after reset -> grant order 0,1,0,1. `psel` stays high across back-to-back transfers; each `rsp_valid` goes to the matching requester, with `rsp_rdata` equal to `prdata`.
- Wait states: read with `pready` low for 3 ACCESS cycles -> `paddr`/`penable` stable for 4 ACCESS cycles; `rsp_valid` one cycle after `pready`; `pstrb`=0.
- Timeout: TIMEOUT_CYCLES=4, `pready` stuck 0 -> after 4 ACCESS cycles `psel` drops, `rsp_valid` pulses with `rsp_slverr`=1 and `rsp_rdata`=0; a late `pready` has no effect.
- Slave error: `pslverr`=1 with `pready`=1 -> `rsp_slverr`=1 on that response only.
- Async reset: `presetn` asserted mid-ACCESS, between clock edges -> `psel`/`penable` go 0 immediately; no `rsp_valid`; after release, req1 is served first only if req0 is idle (pointer back to 0).
